// File: rtl/shift_exec_stage.sv
// Two-stage RV32 execute shift unit (SLL/SRL/SRA) with valid/ready on both sides.
// Right shifts reuse the left barrel shifter by bit-reversing the operand and the result.

module sll_shifter (
  input  logic [31:0] a,
  input  logic [4:0]  sh,
  output logic [31:0] y
);
  logic [31:0] s0, s1, s2, s3;

  assign s0 = sh[0] ? {a[30:0],  1'b0}  : a;
  assign s1 = sh[1] ? {s0[29:0], 2'b0}  : s0;
  assign s2 = sh[2] ? {s1[27:0], 4'b0}  : s1;
  assign s3 = sh[3] ? {s2[23:0], 8'b0}  : s2;
  assign y  = sh[4] ? {s3[15:0], 16'b0} : s3;
endmodule

module shift_exec_stage #(
  parameter int TAG_W   = 4,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [31:0]      s1_a;
  logic [4:0]       s1_sh;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_adv;

  logic [31:0] sll_in, sll_out, srl_res, sra_fill, res_data;
  logic        res_err;
  logic        unused_b_hi;

  assign unused_b_hi = ^in_b[31:5];
  assign in_ready    = ~s1_valid | s1_adv;

  // S1 payload is only loaded on accept, so it also serves as the held output when OUT_REG=0
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_a     <= 32'h0;
      s1_sh    <= 5'h0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_sh    <= in_b[4:0];
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign sll_in = (s1_op == OP_SLL) ? s1_a : rev32(s1_a);

  sll_shifter u_sll (
    .a  (sll_in),
    .sh (s1_sh),
    .y  (sll_out)
  );

  assign srl_res  = rev32(sll_out);
  assign sra_fill = s1_a[31] ? ~(32'hFFFF_FFFF >> s1_sh) : 32'h0;

  always_comb begin
    res_data = 32'h0;
    res_err  = 1'b0;
    case (s1_op)
      OP_SLL:  res_data = sll_out;
      OP_SRL:  res_data = srl_res;
      OP_SRA:  res_data = srl_res | sra_fill;
      default: res_err  = 1'b1;
    endcase
  end

  generate
    if (OUT_REG != 0) begin : g_s2
      logic             s2_valid;
      logic [31:0]      s2_data;
      logic [TAG_W-1:0] s2_tag;
      logic             s2_err;

      assign s1_adv = ~s2_valid | out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= 32'h0;
          s2_tag   <= '0;
          s2_err   <= 1'b0;
        end else if (flush) begin
          s2_valid <= 1'b0;
        end else if (s1_adv) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= res_data;
            s2_tag  <= s1_tag;
            s2_err  <= res_err;
          end
        end
      end

      assign out_valid = s2_valid;
      assign out_data  = s2_data;
      assign out_tag   = s2_tag;
      assign out_err   = s2_err;
    end else begin : g_bypass
      assign s1_adv    = out_ready;
      assign out_valid = s1_valid;
      assign out_data  = res_data;
      assign out_tag   = s1_tag;
      assign out_err   = res_err;
    end
  endgenerate
endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: directed scenarios plus randomized traffic against a
// queue-based reference model using plain shift operators.

module tb_shift_exec_stage;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]       in_op;
  logic [31:0]      in_a, in_b, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  shift_exec_stage #(.TAG_W(TAG_W), .OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  logic last_acc, last_ov;
  logic prev_hold = 1'b0;
  logic [31:0]      prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;

  function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    int   sh = int'(b[4:0]);
    e.tag = tag;
    e.err = 1'b0;
    case (op)
      2'b00:   e.data = a << sh;
      2'b01:   e.data = a >> sh;
      2'b11:   e.data = 32'($signed(a) >>> sh);
      default: begin e.data = 32'h0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Sampled at negedge: inputs and in_ready are settled for the coming posedge.
  task automatic observe();
    exp_t e;
    if (prev_hold) begin
      chk("hold_data", 64'(out_data), 64'(prev_data));
      chk("hold_tag",  64'(out_tag),  64'(prev_tag));
      chk("hold_err",  64'(out_err),  64'(prev_err));
    end
    last_ov  = out_valid;
    last_acc = in_valid & in_ready & ~flush & ~rst;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(out_data), 64'(e.data));
          chk("sb_tag",  64'(out_tag),  64'(e.tag));
          chk("sb_err",  64'(out_err),  64'(e.err));
        end
      end
      if (last_acc) begin
        exp_q.push_back(ref_model(in_op, in_a, in_b, in_tag));
        n_acc++;
      end
    end
    prev_hold = out_valid & ~out_ready & ~flush & ~rst;
    prev_data = out_data;
    prev_tag  = out_tag;
    prev_err  = out_err;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc0;
    logic [11:0] ov_vec;
    int idx;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = 32'h0; in_b = 32'h0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_tag",   64'(out_tag),   64'd0);
    chk("rst_err",   64'(out_err),   64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);

    // latency 2 from accept edge
    send(2'b00, 32'h0000_0001, 32'd31, 4'd3);
    chk("t1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data",  64'(out_data),  64'h8000_0000);
    chk("t1_tag",   64'(out_tag),   64'd3);
    chk("t1_err",   64'(out_err),   64'd0);
    drain();

    send(2'b11, 32'h8000_00F0, 32'h0000_0024, 4'd1);
    tick();
    chk("t2_sra", 64'(out_data), 64'hF800_000F);
    send(2'b01, 32'h8000_00F0, 32'h0000_0024, 4'd2);
    tick();
    chk("t2_srl", 64'(out_data), 64'h0800_000F);
    send(2'b00, 32'h8000_00F0, 32'hFFFF_FFE0, 4'd4);
    tick();
    chk("t2_sll0", 64'(out_data), 64'h8000_00F0);
    drain();

    // 8 back-to-back: out_valid expected on ticks 2..9 of a 12-tick window
    acc0 = n_acc;
    ov_vec = '0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_op = 2'($urandom_range(0, 3)); in_a = $urandom(); in_b = $urandom();
      in_tag = 4'(i + 5);
      tick();
      ov_vec[i] = last_ov;
    end
    chk("t3_accepts", 64'(n_acc - acc0), 64'd8);
    chk("t3_ov_pattern", 64'(ov_vec), 64'h3FC);
    drain();

    // backpressure: only two fit
    out_ready = 1'b0;
    acc0 = n_acc;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 3);
      in_op = 2'b01; in_a = 32'hF0F0_0000 + 32'(idx); in_b = 32'(idx + 1);
      in_tag = 4'(8 + idx);
      tick();
      if (last_acc) idx++;
    end
    chk("t4_accepted", 64'(n_acc - acc0), 64'd2);
    chk("t4_in_ready", 64'(in_ready), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    chk("t4_tag_stable", 64'(out_tag), 64'd8);
    out_ready = 1'b1;
    send(2'b01, 32'hF0F0_0002, 32'd3, 4'd10);
    drain();

    send(2'b10, 32'hDEAD_BEEF, 32'd5, 4'd7);
    tick();
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_err",  64'(out_err),  64'd1);
    chk("t5_tag",  64'(out_tag),  64'd7);
    send(2'b00, 32'h0000_0003, 32'd2, 4'd6);
    tick();
    chk("t5_next_err",  64'(out_err),  64'd0);
    chk("t5_next_data", 64'(out_data), 64'd12);
    drain();

    // flush with both stages full and a request on the input
    out_ready = 1'b0;
    send(2'b00, 32'h1, 32'd1, 4'd1);
    send(2'b00, 32'h2, 32'd1, 4'd2);
    acc0 = n_acc;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'h3; in_tag = 4'd3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_flush_ov", 64'(out_valid), 64'd0);
    chk("t6_flush_acc", 64'(n_acc - acc0), 64'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("t6_flush_empty", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'b11; in_a = 32'hFFFF_0000 | 32'(i); in_b = 32'd4;
      in_tag = 4'(12 + i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data",  64'(out_data),  64'd0);
    chk("t6_rst_tag",   64'(out_tag),   64'd0);
    chk("t6_rst_err",   64'(out_err),   64'd0);
    tick(); tick();
    chk("t6_rst_quiet", 64'(out_valid), 64'd0);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = $urandom();
      in_b      = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1)) * 32'h20 : $urandom();
      in_tag    = 4'($urandom_range(0, 15));
      tick();
    end
    flush = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
